fetch_pc_unit: RTL and testbench

Parametrised fetch-address generator for the fetch stage. It holds the program counter and issues sequential fetch requests to instruction memory over a valid/ready handshake. It accepts trap and branch redirects and tracks in-flight requests in an in-order queue. Memory responses are paired with their PC, and responses for addresses fetched before a redirect are discarded. It sits between the branch/trap logic and the instruction memory port, feeding the decode stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_queue.sv | 68 ++++++
 rtl/fetch_pc_unit.sv | 127 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch PC unit and its in-flight request queue.
// Queue entries hold up to FETCH_ADDR_W bits of PC, so ADDR_W must not exceed it.
package fetch_pkg;

    localparam int unsigned             FETCH_ADDR_W         = 32;
    localparam logic [FETCH_ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned             INSTR_BYTES_DEFAULT  = 4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic                    stale;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_queue.sv
// In-order circular buffer of outstanding fetch requests with a mark-all-stale operation.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module fetch_pc_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic              i_pop,
    input  logic              i_mark_stale,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_pc,
    output logic              o_head_stale
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;
    fetch_entry_t     w_head;

    always_comb begin
        o_empty = (r_wr_ptr == r_rd_ptr);
        o_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                  (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    end

    assign w_do_push    = i_push & ~o_full;
    assign w_do_pop     = i_pop & ~o_empty;
    assign w_head       = r_mem[r_rd_ptr[IDX_W-1:0]];
    assign o_head_pc    = ADDR_W'(w_head.pc);
    assign o_head_stale = w_head.stale;

    // Stale bits of empty slots are don't-care (a push always writes stale=0), so
    // marking every slot is equivalent to marking only the live ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_mark_stale) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_mem[i].stale <= 1'b1;
                end
            end
            if (w_do_push) begin
                r_mem[r_wr_ptr[IDX_W-1:0]] <= '{pc: FETCH_ADDR_W'(i_push_pc), stale: 1'b0};
                r_wr_ptr                   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-address generator: sequential PC, trap/branch redirects, in-order response pairing.
// Defining FETCH_PC_STATS_EN adds saturating redirect_cnt and drop_cnt outputs.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
    parameter int unsigned       INSTR_BYTES  = INSTR_BYTES_DEFAULT,
    parameter int unsigned       DEPTH        = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_pc,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
`ifdef FETCH_PC_STATS_EN
    output logic              proto_err,
    output logic [15:0]       redirect_cnt,
    output logic [15:0]       drop_cnt
`else
    output logic              proto_err
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              r_proto_err;
    logic              w_redirect;
    logic              w_fire;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_head_pc;
    logic              w_head_stale;

    assign w_redirect = trap_valid | redirect_valid;
    assign w_pop      = rsp_valid & ~w_empty;
    assign w_fire     = req_valid & req_ready;

    always_comb begin
        req_valid = !stall && !w_full && !w_redirect;
        req_addr  = r_pc;
    end

    always_comb begin
        w_pc_next = r_pc;
        if (trap_valid) begin
            w_pc_next = trap_pc;
        end else if (redirect_valid) begin
            w_pc_next = redirect_pc;
        end else if (w_fire) begin
            w_pc_next = r_pc + ADDR_W'(INSTR_BYTES);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc        <= RESET_VECTOR;
            r_proto_err <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (rsp_valid && w_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // The head's stale bit is read before any same-cycle redirect takes effect.
    always_comb begin
        out_valid = w_pop && !w_head_stale;
        out_pc    = w_head_pc;
        out_instr = rsp_data;
        proto_err = r_proto_err;
    end

    fetch_pc_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_push       (w_fire),
        .i_push_pc    (r_pc),
        .i_pop        (w_pop),
        .i_mark_stale (w_redirect),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_pc    (w_head_pc),
        .o_head_stale (w_head_stale)
    );

`ifdef FETCH_PC_STATS_EN
    logic [15:0] r_redirect_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_pop & w_head_stale;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_redirect_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != 16'hFFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign drop_cnt     = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random traffic
// against a queue-based reference model. Counter checks run when FETCH_PC_STATS_EN is defined.
module tb_fetch_pc_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IB    = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        proto_err;
`ifdef FETCH_PC_STATS_EN
    logic [15:0] redirect_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } mdl_ent_t;

    mdl_ent_t    m_q[$];
    logic [31:0] m_pc;
    logic        m_perr;
    int          m_redir;
    int          m_drop;

    always #5 CLK = ~CLK;

    fetch_pc_unit #(
        .ADDR_W       (32),
        .RESET_VECTOR (RV),
        .INSTR_BYTES  (IB),
        .DEPTH        (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef FETCH_PC_STATS_EN
        .proto_err      (proto_err),
        .redirect_cnt   (redirect_cnt),
        .drop_cnt       (drop_cnt)
`else
        .proto_err      (proto_err)
`endif
    );

    task automatic model_reset();
        m_q.delete();
        m_pc    = RV;
        m_perr  = 1'b0;
        m_redir = 0;
        m_drop  = 0;
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic tv,
                         input logic [31:0] tpc, input logic rdy, input logic rspv,
                         input logic [31:0] d);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_pc        = tpc;
        req_ready      = rdy;
        rsp_valid      = rspv;
        rsp_data       = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic step();
        logic fire;
        @(posedge CLK);
        fire = !stall && (m_q.size() < DEPTH) && !trap_valid && !redirect_valid && req_ready;
        if (rsp_valid) begin
            if (m_q.size() > 0) begin
                if (m_q[0].stale && m_drop < 65535) m_drop++;
                m_q.delete(0);
            end else begin
                m_perr = 1'b1;
            end
        end
        if (trap_valid || redirect_valid) begin
            foreach (m_q[i]) m_q[i].stale = 1'b1;
            m_pc = trap_valid ? trap_pc : redirect_pc;
            if (m_redir < 65535) m_redir++;
        end else if (fire) begin
            m_q.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + IB;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST_N = 1'b0;
        #2;
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST_N = 1'b0;
        #2;
        model_reset();
        total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b exp=1", req_valid); end
        total++; if (req_addr !== RV) begin bad++; $display("FAIL reset_req_addr got=%h exp=%h", req_addr, RV); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
`ifdef FETCH_PC_STATS_EN
        total++; if (redirect_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", redirect_cnt, drop_cnt);
        end
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
            #1;
            total++; if (req_valid !== 1'b1 || req_addr !== 32'(i * 4)) begin
                bad++; $display("FAIL seq_req_addr%0d got=%b/%h exp=1/%h", i, req_valid, req_addr, 32'(i * 4));
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'hA + 32'(i));
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'hA + 32'(i)) begin
                bad++; $display("FAIL seq_rsp%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_pc, out_instr,
                                32'(i * 4), 32'hA + 32'(i));
            end
            step();
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
            #1;
            total++; if (req_valid !== 1'b1 || req_addr !== RV) begin
                bad++; $display("FAIL noready_hold got=%b/%h exp=1/%h", req_valid, req_addr, RV);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
            #1;
            total++; if (req_valid !== 1'b1 || req_addr !== 32'(i * 4)) begin
                bad++; $display("FAIL fill_addr%0d got=%b/%h exp=1/%h", i, req_valid, req_addr, 32'(i * 4));
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_blocks got=%b exp=0", req_valid); end
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h1111);
        #1;
        total++; if (req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL full_pop got=%b/%b/%h exp=0/1/0", req_valid, out_valid, out_pc);
        end
        step();
        idle();
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin
            bad++; $display("FAIL after_pop got=%b/%h exp=1/10", req_valid, req_addr);
        end
        step();
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'(i));
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
                bad++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, 32'(i * 4));
            end
            step();
        end
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        step();
        step();
        drive(1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b1, 1'b0, '0);
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req got=%b exp=0", req_valid); end
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            bad++; $display("FAIL redir_target got=%b/%h exp=1/100", req_valid, req_addr);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i));
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_drop%0d got=%b exp=0", i, out_valid); end
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h0000_0513);
        #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h0000_0513) begin
            bad++; $display("FAIL redir_rsp got=%b/%h/%h exp=1/100/513", out_valid, out_pc, out_instr);
        end
        step();
        idle();
    endtask

    task automatic test_trap_priority();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        step();
        drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 1'b0, '0);
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL trap_no_req got=%b exp=0", req_valid); end
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'hBEEF);
        #1;
        total++; if (req_addr !== 32'h80) begin bad++; $display("FAIL trap_priority got=%h exp=80", req_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL trap_drop got=%b exp=0", out_valid); end
        step();
        idle();
`ifdef FETCH_PC_STATS_EN
        #1;
        total++; if (redirect_cnt !== 16'd2 || drop_cnt !== 16'd3) begin
            bad++; $display("FAIL stats_directed got=%0d/%0d exp=2/3", redirect_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_proto_err();
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h1);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_rsp_out got=%b exp=0", out_valid); end
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        #1;
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b exp=1", proto_err); end
        step();
        step();
        idle();
        #1;
        total++; if (proto_err !== 1'b1 || req_addr !== 32'h8) begin
            bad++; $display("FAIL proto_sticky got=%b/%h exp=1/8", proto_err, req_addr);
        end
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        total++; if (proto_err !== 1'b0 || req_addr !== RV || req_valid !== 1'b1) begin
            bad++; $display("FAIL midrun_reset got=%b/%h/%b exp=0/%h/1", proto_err, req_addr, req_valid, RV);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h2);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL queue_cleared got=%b exp=0", out_valid); end
        step();
        idle();
        #1;
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_after_reset got=%b exp=1", proto_err); end
    endtask

    task automatic test_random();
        logic        e_req_valid;
        logic        e_out_valid;
        logic [31:0] d;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            d = $urandom();
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 2) != 0),
                  (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0), d);
            #1;
            e_req_valid = !stall && (m_q.size() < DEPTH) && !trap_valid && !redirect_valid;
            e_out_valid = rsp_valid && (m_q.size() > 0) && !m_q[0].stale;
            total++; if (req_valid !== e_req_valid || req_addr !== m_pc) begin
                bad++; $display("FAIL rnd_req c%0d got=%b/%h exp=%b/%h", n, req_valid, req_addr, e_req_valid, m_pc);
            end
            total++; if (out_valid !== e_out_valid) begin
                bad++; $display("FAIL rnd_out_valid c%0d got=%b exp=%b", n, out_valid, e_out_valid);
            end
            if (e_out_valid) begin
                total++; if (out_pc !== m_q[0].pc || out_instr !== d) begin
                    bad++; $display("FAIL rnd_out c%0d got=%h/%h exp=%h/%h", n, out_pc, out_instr, m_q[0].pc, d);
                end
            end
            total++; if (proto_err !== m_perr) begin
                bad++; $display("FAIL rnd_proto c%0d got=%b exp=%b", n, proto_err, m_perr);
            end
            step();
        end
        idle();
`ifdef FETCH_PC_STATS_EN
        #1;
        total++; if (redirect_cnt !== 16'(m_redir) || drop_cnt !== 16'(m_drop)) begin
            bad++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", redirect_cnt, drop_cnt, m_redir, m_drop);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect();
        test_trap_priority();
        test_proto_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
